// File: rtl/alu_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared opcode encodings, opcode legality check and the
//                arbiter state type used by the ALU sharing block.
//                No ports (package).
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam int unsigned ALU_OP_W = 6;

    typedef logic [ALU_OP_W-1:0] alu_op_t;

    // RV32I register-register ALU operations understood by the shared ALU.
    localparam alu_op_t ALU_ADD  = 6'b011001;
    localparam alu_op_t ALU_SUB  = 6'b011011;
    localparam alu_op_t ALU_AND  = 6'b011101;
    localparam alu_op_t ALU_OR   = 6'b011111;
    localparam alu_op_t ALU_XOR  = 6'b100001;
    localparam alu_op_t ALU_SLT  = 6'b100011;
    localparam alu_op_t ALU_SLTU = 6'b100101;
    localparam alu_op_t ALU_SLL  = 6'b100111;
    localparam alu_op_t ALU_SRL  = 6'b101001;
    localparam alu_op_t ALU_SRA  = 6'b101011;

    // Sharing block sequencing: wait for a request, drive the ALU for one
    // cycle, then hold the response until the owner consumes it.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } arb_state_t;

    // True for the ten opcodes the ALU implements. Anything else is answered
    // with a zero result and the error flag instead of the ALU output.
    function automatic logic is_legal_alu_op(input alu_op_t op);
        logic legal;
        case (op)
            ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
            ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA: legal = 1'b1;
            default:                                     legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage : alu_pkg
`default_nettype wire

// File: rtl/rr_arbiter2.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : rr_arbiter2
//  Description : Two-way round-robin arbiter. A lone requester always wins;
//                on a tie the port that was not granted last wins. The
//                last-grant pointer only moves when the caller signals that
//                the grant was actually used (i_advance).
//  Ports       : i_clk        - clock, rising edge
//                i_rst        - asynchronous active-high reset (pointer -> 1)
//                i_request    - request vector, one bit per port
//                i_advance    - the current grant resulted in a transfer
//                o_grant      - one-hot grant, or zero when nobody requests
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter2 (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [1:0] i_request,
    input  logic       i_advance,
    output logic [1:0] o_grant
);

    // Index of the port granted most recently. Resetting to 1 makes port 0
    // the winner of the first tie.
    logic r_last_grant;

    always_comb begin
        o_grant = 2'b00;
        case (i_request)
            2'b01:   o_grant = 2'b01;
            2'b10:   o_grant = 2'b10;
            2'b11:   o_grant = r_last_grant ? 2'b01 : 2'b10;
            default: o_grant = 2'b00;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_last_grant <= 1'b1;
        end else if (i_advance) begin
            // Grant is one-hot whenever a transfer happens, so bit 1 is the
            // index of the winner.
            r_last_grant <= o_grant[1];
        end
    end

endmodule : rr_arbiter2
`default_nettype wire

// File: rtl/alu_share_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : alu_share_arbiter
//  Description : Shares one combinational RV32I ALU between two requesters.
//                Requests are accepted through a valid/ready handshake after
//                round-robin arbitration, operands are registered and driven
//                to the ALU for one cycle, and the captured result is
//                returned on the owner's response handshake. Illegal opcodes
//                are accepted and answered with result 0 and o_rsp_err=1.
//                Only NUM_REQ = 2 is supported.
//  Ports       : i_clk, i_rst       - clock / asynchronous active-high reset
//                i_req_valid/ready  - per-port request handshake
//                i_req_op/a/b       - per-port opcode and operands
//                o_rsp_valid        - per-port response valid (owner only)
//                i_rsp_ready        - per-port response consumed
//                o_rsp_result/err   - shared response data and error flag
//                o_alu_op/a/b       - operands driven to the external ALU
//                i_alu_result       - combinational result from the ALU
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int NUM_REQ = 2
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [NUM_REQ-1:0]            i_req_valid,
    output logic [NUM_REQ-1:0]            o_req_ready,
    input  logic [NUM_REQ-1:0][5:0]       i_req_op,
    input  logic [NUM_REQ-1:0][WIDTH-1:0] i_req_a,
    input  logic [NUM_REQ-1:0][WIDTH-1:0] i_req_b,
    output logic [NUM_REQ-1:0]            o_rsp_valid,
    input  logic [NUM_REQ-1:0]            i_rsp_ready,
    output logic [WIDTH-1:0]              o_rsp_result,
    output logic                          o_rsp_err,
    output logic [5:0]                    o_alu_op,
    output logic [WIDTH-1:0]              o_alu_a,
    output logic [WIDTH-1:0]              o_alu_b,
    input  logic [WIDTH-1:0]              i_alu_result
);

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    arb_state_t       r_state;
    arb_state_t       w_state_next;

    alu_op_t          r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_owner;        // index of the port being served
    logic [WIDTH-1:0] r_result;
    logic             r_err;

    logic [1:0]       w_grant;
    logic             w_winner;       // index of the current grant
    logic             w_transfer;     // a request handshake completes now
    logic             w_owner_rsp_ready;
    logic             w_accept_window;
    logic             w_capture;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    rr_arbiter2 u_rr_arbiter2 (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_request (i_req_valid),
        .i_advance (w_transfer),
        .o_grant   (w_grant)
    );

    assign w_winner          = w_grant[1];
    assign w_transfer        = |(i_req_valid & o_req_ready);
    // Only the owner can release the response; the other port's ready is
    // deliberately not looked at.
    assign w_owner_rsp_ready = i_rsp_ready[r_owner];

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_transfer) begin
                    w_state_next = ST_EXEC;
                end
            end
            ST_EXEC: begin
                w_state_next = ST_RESP;
            end
            ST_RESP: begin
                // A new request may be taken in the same cycle the response
                // is consumed, giving one operation every two cycles.
                if (w_owner_rsp_ready) begin
                    w_state_next = w_transfer ? ST_EXEC : ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_accept_window = 1'b0;
        w_capture       = 1'b0;
        o_rsp_valid     = '0;
        case (r_state)
            ST_IDLE: begin
                w_accept_window = 1'b1;
            end
            ST_EXEC: begin
                w_capture = 1'b1;
            end
            ST_RESP: begin
                o_rsp_valid[r_owner] = 1'b1;
                w_accept_window      = w_owner_rsp_ready;
            end
            default: begin
                w_accept_window = 1'b0;
            end
        endcase
        // The reset term keeps ready low for the whole reset pulse, not just
        // after the state register has been cleared.
        o_req_ready = (w_accept_window && !i_rst) ? w_grant : '0;
    end

    // ------------------------------------------------------------------
    // Operand and response registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_op     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_owner  <= 1'b0;
            r_result <= '0;
            r_err    <= 1'b0;
        end else begin
            if (w_transfer) begin
                r_op    <= i_req_op[w_winner];
                r_a     <= i_req_a[w_winner];
                r_b     <= i_req_b[w_winner];
                r_owner <= w_winner;
            end
            if (w_capture) begin
                // An unknown opcode gives no meaningful ALU output, so the
                // result is forced to zero and flagged instead.
                if (is_legal_alu_op(r_op)) begin
                    r_result <= i_alu_result;
                    r_err    <= 1'b0;
                end else begin
                    r_result <= '0;
                    r_err    <= 1'b1;
                end
            end
        end
    end

    // The operand registers feed the ALU directly; they keep their values
    // outside the execute cycle, which avoids needless toggling in the ALU.
    assign o_alu_op     = r_op;
    assign o_alu_a      = r_a;
    assign o_alu_b      = r_b;
    assign o_rsp_result = r_result;
    assign o_rsp_err    = r_err;

endmodule : alu_share_arbiter
`default_nettype wire
